// File: rtl/riscv_defines.sv
// Shared encodings for the decoded control bundle handed from decode to execute.
package riscv_defines;

    typedef enum logic [1:0] {
        CFLOW_NONE   = 2'd0,
        CFLOW_BRANCH = 2'd1,
        CFLOW_JAL    = 2'd2,
        CFLOW_JALR   = 2'd3
    } cflow_mode_e;

    typedef enum logic [1:0] {
        SYSOP_NORMAL = 2'd0,
        SYSOP_ECALL  = 2'd1,
        SYSOP_EBREAK = 2'd2,
        SYSOP_MRET   = 2'd3
    } sysop_mode_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4,
        IMM_Z = 3'd5
    } immsrc_e;

    typedef enum logic [1:0] {
        SRCA_RS1  = 2'd0,
        SRCA_PC   = 2'd1,
        SRCA_ZERO = 2'd2
    } alusrc_a_e;

    typedef enum logic {
        SRCB_RS2 = 1'b0,
        SRCB_IMM = 1'b1
    } alusrc_b_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_ARITH = 2'd1,
        ALUOP_MUL   = 2'd2
    } aluop_e;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } memaccess_e;

    typedef enum logic [1:0] {
        RESULT_ALU     = 2'd0,
        RESULT_MEM     = 2'd1,
        RESULT_PCPLUS4 = 2'd2,
        RESULT_CSR     = 2'd3
    } resultsrc_e;

endpackage

// File: rtl/control_decode_queue.sv
// Decode front-end: decodes fetched words on intake and buffers the decoded
// bundles in a small FIFO. Serialising instructions (FENCE.I, ECALL, EBREAK,
// MRET) optionally block further intake until they leave the queue.
module control_decode_queue
    import riscv_defines::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter bit          EN_M      = 1'b0,
    parameter bit          SERIALIZE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output cflow_mode_e out_cflow_mode,
    output sysop_mode_e out_sysop_mode,
    output immsrc_e     out_immsrc,
    output alusrc_a_e   out_alusrc_a,
    output alusrc_b_e   out_alusrc_b,
    output aluop_e      out_aluop,
    output memaccess_e  out_memaccess,
    output resultsrc_e  out_resultsrc,
    output logic        out_fencei,
    output logic        out_regwrite,
    output logic        out_is_rtype,
    output logic        out_is_alt,
    output logic        out_illegal_op
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        cflow_mode_e cflow_mode;
        sysop_mode_e sysop_mode;
        immsrc_e     immsrc;
        alusrc_a_e   alusrc_a;
        alusrc_b_e   alusrc_b;
        aluop_e      aluop;
        memaccess_e  memaccess;
        resultsrc_e  resultsrc;
        logic        fencei;
        logic        regwrite;
        logic        is_rtype;
        logic        is_alt;
        logic        illegal_op;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             entry_d;
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [CNT_W-1:0]   ser_q;
    logic [CNT_W-1:0]   ser_d;
    logic               accept;
    logic               pop;
    logic               ser_in;
    logic               ser_head;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] imm12;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign imm12  = in_instr[31:20];

    // Decode the offered word into the entry that would be written on accept.
    always_comb begin
        entry_d       = '0;
        entry_d.pc    = in_pc;
        entry_d.instr = in_instr;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE || funct7 == F7_ALT) begin
                    entry_d.regwrite = 1'b1;
                    entry_d.is_rtype = 1'b1;
                    entry_d.aluop    = ALUOP_ARITH;
                    entry_d.is_alt   = (funct7 == F7_ALT);
                end else if (funct7 == F7_MUL && EN_M) begin
                    entry_d.regwrite = 1'b1;
                    entry_d.is_rtype = 1'b1;
                    entry_d.aluop    = ALUOP_MUL;
                end else begin
                    entry_d.illegal_op = 1'b1;
                end
            end
            OPC_OPIMM: begin
                entry_d.regwrite = 1'b1;
                entry_d.aluop    = ALUOP_ARITH;
                entry_d.alusrc_b = SRCB_IMM;
                entry_d.immsrc   = IMM_I;
                entry_d.is_alt   = (funct7 == F7_ALT);
            end
            OPC_LOAD: begin
                entry_d.regwrite  = 1'b1;
                entry_d.memaccess = MEM_READ;
                entry_d.aluop     = ALUOP_ADD;
                entry_d.alusrc_b  = SRCB_IMM;
                entry_d.immsrc    = IMM_I;
                entry_d.resultsrc = RESULT_MEM;
            end
            OPC_STORE: begin
                entry_d.memaccess = MEM_WRITE;
                entry_d.aluop     = ALUOP_ADD;
                entry_d.alusrc_b  = SRCB_IMM;
                entry_d.immsrc    = IMM_S;
            end
            OPC_LUI: begin
                entry_d.regwrite = 1'b1;
                entry_d.alusrc_a = SRCA_ZERO;
                entry_d.alusrc_b = SRCB_IMM;
                entry_d.immsrc   = IMM_U;
            end
            OPC_AUIPC: begin
                entry_d.regwrite = 1'b1;
                entry_d.alusrc_a = SRCA_PC;
                entry_d.alusrc_b = SRCB_IMM;
                entry_d.immsrc   = IMM_U;
            end
            OPC_BRANCH: begin
                entry_d.cflow_mode = CFLOW_BRANCH;
                entry_d.immsrc     = IMM_B;
            end
            OPC_JAL: begin
                entry_d.cflow_mode = CFLOW_JAL;
                entry_d.immsrc     = IMM_J;
                entry_d.resultsrc  = RESULT_PCPLUS4;
                entry_d.regwrite   = 1'b1;
            end
            OPC_JALR: begin
                entry_d.cflow_mode = CFLOW_JALR;
                entry_d.immsrc     = IMM_I;
                entry_d.alusrc_b   = SRCB_IMM;
                entry_d.resultsrc  = RESULT_PCPLUS4;
                entry_d.regwrite   = 1'b1;
            end
            OPC_MISCMEM: begin
                entry_d.fencei = (funct3 == 3'b001);
            end
            OPC_SYSTEM: begin
                if (funct3 == 3'b000) begin
                    case (imm12)
                        12'h000: entry_d.sysop_mode = SYSOP_ECALL;
                        12'h001: entry_d.sysop_mode = SYSOP_EBREAK;
                        12'h302: entry_d.sysop_mode = SYSOP_MRET;
                        12'h105: entry_d.sysop_mode = SYSOP_NORMAL;  // WFI retires as a no-op
                        default: entry_d.illegal_op = 1'b1;
                    endcase
                end else begin
                    entry_d.immsrc    = IMM_Z;
                    entry_d.resultsrc = RESULT_CSR;
                    entry_d.regwrite  = 1'b1;
                end
            end
            default: entry_d.illegal_op = 1'b1;
        endcase
    end

    assign head      = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign in_ready  = (count_q != CNT_W'(DEPTH)) && ((ser_q == '0) || !SERIALIZE);
    assign accept    = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign ser_in    = entry_d.fencei || (entry_d.sysop_mode != SYSOP_NORMAL);
    assign ser_head  = head.fencei || (head.sysop_mode != SYSOP_NORMAL);

    // Next occupancy and next count of queued serialising entries.
    always_comb begin
        count_d = count_q;
        if (accept && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !accept) begin
            count_d = count_q - CNT_W'(1);
        end
        ser_d = ser_q;
        if (accept && ser_in && !(pop && ser_head)) begin
            ser_d = ser_q + CNT_W'(1);
        end else if (pop && ser_head && !(accept && ser_in)) begin
            ser_d = ser_q - CNT_W'(1);
        end
        if (!SERIALIZE) begin
            ser_d = '0;
        end
    end

    // FIFO storage, pointers and counters; flush empties the queue at the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ser_q    <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ser_q    <= '0;
        end else begin
            count_q <= count_d;
            ser_q   <= ser_d;
            if (accept) begin
                mem_q[wr_ptr_q] <= entry_d;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    assign out_pc         = head.pc;
    assign out_instr      = head.instr;
    assign out_rd         = head.instr[11:7];
    assign out_rs1        = head.instr[19:15];
    assign out_rs2        = head.instr[24:20];
    assign out_cflow_mode = head.cflow_mode;
    assign out_sysop_mode = head.sysop_mode;
    assign out_immsrc     = head.immsrc;
    assign out_alusrc_a   = head.alusrc_a;
    assign out_alusrc_b   = head.alusrc_b;
    assign out_aluop      = head.aluop;
    assign out_memaccess  = head.memaccess;
    assign out_resultsrc  = head.resultsrc;
    assign out_fencei     = head.fencei;
    assign out_regwrite   = head.regwrite;
    assign out_is_rtype   = head.is_rtype;
    assign out_is_alt     = head.is_alt;
    assign out_illegal_op = head.illegal_op;

endmodule

// File: tb/tb_control_decode_queue.sv
// Bench for control_decode_queue: instance A (DEPTH=4, EN_M=0, SERIALIZE=1)
// runs directed and random traffic against a queue-based reference model;
// instance B (DEPTH=2, EN_M=1, SERIALIZE=0) gets a short directed sequence.
module tb_control_decode_queue;
    import riscv_defines::*;

    localparam int unsigned A_DEPTH = 4;

    localparam logic [31:0] W_ADD    = 32'h003100B3;
    localparam logic [31:0] W_MUL    = 32'h023100B3;
    localparam logic [31:0] W_FENCEI = 32'h0000100F;
    localparam logic [31:0] W_ECALL  = 32'h00000073;
    localparam logic [31:0] W_CSRRW  = 32'h34011073;
    localparam logic [31:0] W_BAD    = 32'hFFFFFFFF;
    localparam logic [31:0] W_ADDI   = 32'h00108093;

    localparam int NPOOL = 22;
    logic [31:0] pool [NPOOL] = '{
        32'h003100B3, 32'h023100B3, 32'h40310133, 32'h043100B3, 32'h0000A083,
        32'h0010A023, 32'h000010B7, 32'h00001097, 32'h00208063, 32'h0000006F,
        32'h000080E7, 32'h00108093, 32'h4010D093, 32'h0FF0000F, 32'h0000100F,
        32'h00000073, 32'h00100073, 32'h30200073, 32'h10500073, 32'h34011073,
        32'hFFFFFFFF, 32'h00200073
    };

    typedef struct packed {
        cflow_mode_e cflow;
        sysop_mode_e sysop;
        immsrc_e     imm;
        alusrc_a_e   srca;
        alusrc_b_e   srcb;
        aluop_e      aluop;
        memaccess_e  mem;
        resultsrc_e  res;
        logic        fencei;
        logic        regwrite;
        logic        rtype;
        logic        alt;
        logic        illegal;
    } ctl_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        ctl_t        ctl;
    } ent_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // instance A
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_instr, a_in_pc, a_out_pc, a_out_instr;
    logic [4:0]  a_out_rd, a_out_rs1, a_out_rs2;
    cflow_mode_e a_out_cflow_mode;
    sysop_mode_e a_out_sysop_mode;
    immsrc_e     a_out_immsrc;
    alusrc_a_e   a_out_alusrc_a;
    alusrc_b_e   a_out_alusrc_b;
    aluop_e      a_out_aluop;
    memaccess_e  a_out_memaccess;
    resultsrc_e  a_out_resultsrc;
    logic        a_out_fencei, a_out_regwrite, a_out_is_rtype, a_out_is_alt, a_out_illegal_op;
    ctl_t        a_ctl;

    // instance B
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_instr, b_in_pc, b_out_pc, b_out_instr;
    logic [4:0]  b_out_rd, b_out_rs1, b_out_rs2;
    cflow_mode_e b_out_cflow_mode;
    sysop_mode_e b_out_sysop_mode;
    immsrc_e     b_out_immsrc;
    alusrc_a_e   b_out_alusrc_a;
    alusrc_b_e   b_out_alusrc_b;
    aluop_e      b_out_aluop;
    memaccess_e  b_out_memaccess;
    resultsrc_e  b_out_resultsrc;
    logic        b_out_fencei, b_out_regwrite, b_out_is_rtype, b_out_is_alt, b_out_illegal_op;

    assign a_ctl = {a_out_cflow_mode, a_out_sysop_mode, a_out_immsrc, a_out_alusrc_a,
                    a_out_alusrc_b, a_out_aluop, a_out_memaccess, a_out_resultsrc,
                    a_out_fencei, a_out_regwrite, a_out_is_rtype, a_out_is_alt,
                    a_out_illegal_op};

    control_decode_queue #(.DEPTH(A_DEPTH), .EN_M(1'b0), .SERIALIZE(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr), .in_pc(a_in_pc),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc), .out_instr(a_out_instr),
        .out_rd(a_out_rd), .out_rs1(a_out_rs1), .out_rs2(a_out_rs2),
        .out_cflow_mode(a_out_cflow_mode), .out_sysop_mode(a_out_sysop_mode),
        .out_immsrc(a_out_immsrc), .out_alusrc_a(a_out_alusrc_a), .out_alusrc_b(a_out_alusrc_b),
        .out_aluop(a_out_aluop), .out_memaccess(a_out_memaccess), .out_resultsrc(a_out_resultsrc),
        .out_fencei(a_out_fencei), .out_regwrite(a_out_regwrite), .out_is_rtype(a_out_is_rtype),
        .out_is_alt(a_out_is_alt), .out_illegal_op(a_out_illegal_op)
    );

    control_decode_queue #(.DEPTH(2), .EN_M(1'b1), .SERIALIZE(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_pc(b_in_pc),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc), .out_instr(b_out_instr),
        .out_rd(b_out_rd), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2),
        .out_cflow_mode(b_out_cflow_mode), .out_sysop_mode(b_out_sysop_mode),
        .out_immsrc(b_out_immsrc), .out_alusrc_a(b_out_alusrc_a), .out_alusrc_b(b_out_alusrc_b),
        .out_aluop(b_out_aluop), .out_memaccess(b_out_memaccess), .out_resultsrc(b_out_resultsrc),
        .out_fencei(b_out_fencei), .out_regwrite(b_out_regwrite), .out_is_rtype(b_out_is_rtype),
        .out_is_alt(b_out_is_alt), .out_illegal_op(b_out_illegal_op)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode: what each RV32I/Zicsr instruction class asks of the datapath.
    function automatic ctl_t ref_decode(input logic [31:0] w, input bit en_m);
        ctl_t c;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] i12;
        c   = '0;
        op  = w[6:0];
        f3  = w[14:12];
        f7  = w[31:25];
        i12 = w[31:20];
        if (op == 7'h33) begin
            if (f7 == 7'h00 || f7 == 7'h20) begin
                c.regwrite = 1; c.rtype = 1; c.aluop = ALUOP_ARITH; c.alt = (f7 == 7'h20);
            end else if (f7 == 7'h01 && en_m) begin
                c.regwrite = 1; c.rtype = 1; c.aluop = ALUOP_MUL;
            end else begin
                c.illegal = 1;
            end
        end else if (op == 7'h13) begin
            c.regwrite = 1; c.aluop = ALUOP_ARITH; c.srcb = SRCB_IMM; c.alt = (f7 == 7'h20);
        end else if (op == 7'h03) begin
            c.regwrite = 1; c.mem = MEM_READ; c.srcb = SRCB_IMM; c.res = RESULT_MEM;
        end else if (op == 7'h23) begin
            c.mem = MEM_WRITE; c.srcb = SRCB_IMM; c.imm = IMM_S;
        end else if (op == 7'h37) begin
            c.regwrite = 1; c.srca = SRCA_ZERO; c.srcb = SRCB_IMM; c.imm = IMM_U;
        end else if (op == 7'h17) begin
            c.regwrite = 1; c.srca = SRCA_PC; c.srcb = SRCB_IMM; c.imm = IMM_U;
        end else if (op == 7'h63) begin
            c.cflow = CFLOW_BRANCH; c.imm = IMM_B;
        end else if (op == 7'h6F) begin
            c.cflow = CFLOW_JAL; c.imm = IMM_J; c.res = RESULT_PCPLUS4; c.regwrite = 1;
        end else if (op == 7'h67) begin
            c.cflow = CFLOW_JALR; c.srcb = SRCB_IMM; c.res = RESULT_PCPLUS4; c.regwrite = 1;
        end else if (op == 7'h0F) begin
            c.fencei = (f3 == 3'b001);
        end else if (op == 7'h73) begin
            if (f3 != 3'b000) begin
                c.imm = IMM_Z; c.res = RESULT_CSR; c.regwrite = 1;
            end else if (i12 == 12'h000) c.sysop = SYSOP_ECALL;
            else if (i12 == 12'h001)     c.sysop = SYSOP_EBREAK;
            else if (i12 == 12'h302)     c.sysop = SYSOP_MRET;
            else if (i12 != 12'h105)     c.illegal = 1;
        end else begin
            c.illegal = 1;
        end
        return c;
    endfunction

    ent_t mq[$];

    function automatic int ser_pending();
        int n = 0;
        foreach (mq[i]) if (mq[i].ctl.fencei || mq[i].ctl.sysop != SYSOP_NORMAL) n++;
        return n;
    endfunction

    task automatic check_a();
        chk("out_valid", a_out_valid, mq.size() != 0);
        chk("in_ready", a_in_ready, (mq.size() < A_DEPTH) && (ser_pending() == 0));
        if (mq.size() != 0) begin
            chk("head_pc", a_out_pc, mq[0].pc);
            chk("head_instr", a_out_instr, mq[0].instr);
            chk("head_ctl", a_ctl, mq[0].ctl);
            chk("head_regs", {a_out_rd, a_out_rs1, a_out_rs2},
                {mq[0].instr[11:7], mq[0].instr[19:15], mq[0].instr[24:20]});
        end
    endtask

    // One cycle on instance A: check current state, drive inputs, advance model.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        bit   rdy;
        bit   acc;
        bit   pp;
        ent_t e;
        @(negedge clk);
        check_a();
        a_in_valid  = v;
        a_in_instr  = ins;
        a_in_pc     = pc;
        a_out_ready = ordy;
        a_flush     = fl;
        rdy = (mq.size() < A_DEPTH) && (ser_pending() == 0);
        acc = v && rdy && !fl;
        pp  = (mq.size() != 0) && ordy && !fl;
        if (fl) begin
            mq.delete();
        end else begin
            if (pp) void'(mq.pop_front());
            if (acc) begin
                e.pc = pc; e.instr = ins; e.ctl = ref_decode(ins, 1'b0);
                mq.push_back(e);
            end
        end
    endtask

    function automatic logic [31:0] pick();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return pool[$urandom_range(0, NPOOL - 1)];
    endfunction

    task automatic random_run(input int n);
        for (int k = 0; k < n; k++) begin
            step($urandom_range(0, 3) != 0, pick(), $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
        end
    endtask

    task automatic reset_a();
        @(negedge clk);
        a_in_valid = 0; a_out_ready = 0; a_flush = 0;
        rst_n = 0;
        #1;
        mq.delete();
        check_a();
        chk("rst_pc", a_out_pc, 32'h0);
        chk("rst_instr", a_out_instr, 32'h0);
        chk("rst_ctl", a_ctl, '0);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        a_flush = 0; a_in_valid = 0; a_in_instr = 0; a_in_pc = 0; a_out_ready = 0;
        b_flush = 0; b_in_valid = 0; b_in_instr = 0; b_in_pc = 0; b_out_ready = 0;

        repeat (2) @(negedge clk);
        chk("rst_valid", a_out_valid, 1'b0);
        chk("rst_ready", a_in_ready, 1'b1);
        chk("rst_ctl", a_ctl, '0);
        chk("rst_pc", a_out_pc, 32'h0);
        chk("b_rst_ready", b_in_ready, 1'b1);
        chk("b_rst_valid", b_out_valid, 1'b0);
        rst_n = 1;

        // add x1,x2,x3
        step(1, W_ADD, 32'h100, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("add_valid", a_out_valid, 1'b1);
        chk("add_aluop", a_out_aluop, ALUOP_ARITH);
        chk("add_regwrite", a_out_regwrite, 1'b1);
        chk("add_rtype", a_out_is_rtype, 1'b1);
        chk("add_regs", {a_out_rd, a_out_rs1, a_out_rs2}, {5'd1, 5'd2, 5'd3});
        chk("add_illegal", a_out_illegal_op, 1'b0);
        step(0, 0, 0, 1, 0);

        // mul without M extension
        step(1, W_MUL, 32'h104, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("mul_illegal_nom", a_out_illegal_op, 1'b1);

        // fill past DEPTH, pop while full, drain across pointer wrap
        for (int i = 0; i < 5; i++) step(1, W_ADDI, 32'h200 + 32'(4 * i), 0, 0);
        chk("full_ready", a_in_ready, 1'b0);
        step(1, W_ADDI, 32'h300, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("after_pop_ready", a_in_ready, 1'b1);
        repeat (5) step(0, 0, 0, 1, 0);

        // fence.i serialisation
        step(1, W_FENCEI, 32'h400, 0, 0);
        repeat (3) step(1, W_ADD, 32'h404, 0, 0);
        chk("fencei_stall", a_in_ready, 1'b0);
        chk("fencei_head", a_out_fencei, 1'b1);
        step(1, W_ADD, 32'h404, 1, 0);
        step(1, W_ADD, 32'h404, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        // ecall serialisation
        step(1, W_ECALL, 32'h440, 0, 0);
        repeat (3) step(1, W_ADD, 32'h444, 0, 0);
        chk("ecall_stall", a_in_ready, 1'b0);
        chk("ecall_sysop", a_out_sysop_mode, SYSOP_ECALL);
        step(1, W_ADD, 32'h444, 1, 0);
        step(1, W_ADD, 32'h444, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        // flush with a word offered in the same cycle
        for (int i = 0; i < 3; i++) step(1, W_ADD, 32'h500 + 32'(4 * i), 0, 0);
        step(1, W_ADDI, 32'h5F0, 1, 1);
        step(0, 0, 0, 0, 0);
        chk("flush_valid", a_out_valid, 1'b0);
        chk("flush_ready", a_in_ready, 1'b1);

        // illegal word then CSR access
        step(1, W_BAD, 32'h600, 0, 0);
        step(1, W_CSRRW, 32'h604, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("bad_illegal", a_out_illegal_op, 1'b1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("csr_res", a_out_resultsrc, RESULT_CSR);
        chk("csr_imm", a_out_immsrc, IMM_Z);
        chk("csr_regwrite", a_out_regwrite, 1'b1);
        step(0, 0, 0, 1, 0);

        // instance B: M extension on, no serialisation, DEPTH 2
        @(negedge clk);
        b_in_valid = 1; b_in_instr = W_MUL; b_in_pc = 32'h40; b_out_ready = 0;
        @(negedge clk);
        chk("b_mul_aluop", b_out_aluop, ALUOP_MUL);
        chk("b_mul_illegal", b_out_illegal_op, 1'b0);
        chk("b_one_ready", b_in_ready, 1'b1);
        b_in_instr = W_ECALL; b_in_pc = 32'h44;
        @(negedge clk);
        b_in_valid = 0;
        chk("b_full_ready", b_in_ready, 1'b0);
        chk("b_head_pc", b_out_pc, 32'h40);
        b_out_ready = 1;
        @(negedge clk);
        chk("b_ecall_sysop", b_out_sysop_mode, SYSOP_ECALL);
        chk("b_ecall_pc", b_out_pc, 32'h44);
        chk("b_noser_ready", b_in_ready, 1'b1);
        @(negedge clk);
        chk("b_empty", b_out_valid, 1'b0);
        b_out_ready = 0;

        random_run(1500);
        reset_a();
        random_run(800);
        @(negedge clk);
        check_a();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/control_decode_queue.md
# control_decode_queue

Parametrised decode front-end between fetch and the execute/hazard logic. Accepts raw 32-bit instructions over a valid/ready handshake, decodes each into the core's control bundle, and stores decoded entries in a DEPTH-entry FIFO. Adds optional M-extension decode, flush, and serialisation of FENCE.I/ECALL/EBREAK/MRET.

## Interface

**Parameters**
- DEPTH, 2: FIFO entries; power of two, 2..16.
- EN_M, 0: 1 decodes OP funct7=0000001 as ALUOP_MUL; 0 flags it illegal.
- SERIALIZE, 1: 1 blocks intake while a serialising instruction is queued.

**Ports**
- clk  in  1  clock; rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- flush  in  1  discard all entries and the current input.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  queue accepts one instruction this cycle.
- in_instr  in  32  raw instruction.
- in_pc  in  32  instruction PC.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer pops the head.
- out_pc, out_instr  out  32 each  head PC and raw word.
- out_rd, out_rs1, out_rs2  out  5 each  instr[11:7], [19:15], [24:20].
- out_cflow_mode, out_sysop_mode, out_immsrc, out_alusrc_a, out_alusrc_b, out_aluop, out_memaccess, out_resultsrc  out  riscv_defines enum widths  decoded controls.
- out_fencei, out_regwrite, out_is_rtype, out_is_alt, out_illegal_op  out  1 each  decoded flags.

## Operation

- Decode is combinational on in_instr. The decoded bundle, PC and raw word are written into the FIFO on accept. Outputs come from the head entry's storage.
- Accept: in_valid && in_ready && !flush. Pop: out_valid && out_ready && !flush.
- Occupancy count is 0..DEPTH. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Decode defaults match RV32I + Zicsr:
  - OP: regwrite=1, is_rtype=1, ALUOP_ARITH. funct7 0100000 sets is_alt. funct7 0000001 gives ALUOP_MUL if EN_M=1, otherwise illegal. Any other funct7 is illegal.
  - OP-IMM: ALUOP_ARITH, SRCB_IMM. is_alt = (funct7 == 0100000).
  - LOAD/STORE: MEM_READ/MEM_WRITE, ALUOP_ADD.
  - LUI: SRCA_ZERO. AUIPC: SRCA_PC.
  - BRANCH: CFLOW_BRANCH, IMM_B.
  - JAL/JALR: RESULT_PCPLUS4, regwrite=1.
  - MISC-MEM: fencei = (funct3 == 001).
  - SYSTEM, funct3=000: imm 000/001/302 give ECALL/EBREAK/MRET; imm 105 (WFI) is a no-op; any other imm is illegal.
  - SYSTEM, funct3≠000: IMM_Z, RESULT_CSR, regwrite=1.
  - Any other opcode: illegal_op=1, all other fields at defaults.
- Illegal instructions are queued normally with out_illegal_op=1; the queue never drops them.
- Serialising set: fencei=1 or sysop_mode≠SYSOP_NORMAL.
  - With SERIALIZE=1, a serialise counter tracks queued serialising entries.
  - in_ready is low while the counter is non-zero, even if space remains.
- in_ready = (count≠DEPTH) && (serialise counter == 0 || SERIALIZE == 0). It is registered-state-derived and has no combinational path from out_ready.

## Timing

- Reset (rst_n low, asynchronous) clears count, pointers and serialise counter to 0. Outputs after reset: out_valid=0, in_ready=1, every out_* field 0.
- Latency: an instruction accepted at edge N has out_valid=1 after edge N, i.e. one cycle.
- Throughput: one accept and one pop per cycle. A simultaneous accept and pop leaves count unchanged.
- Full: count==DEPTH drives in_ready=0. A pop in that same cycle does not make the input acceptable; in_ready rises the next cycle.
- Empty: out_valid=0. out_* holds the last-written storage, which is don't-care.
- Flush: at the next edge, count, pointers and serialise counter go to 0. Both the in_valid and out_ready of the flush cycle are ignored. flush together with reset: reset wins.
- Serialiser: popping the serialising entry decrements the counter at that edge, so in_ready may rise the following cycle. Flush clears the counter.
- Reset deasserted mid-handshake: the first accept is possible on the first edge with rst_n=1.

## Test plan

- Reset, then push 0x003100B3 (add x1,x2,x3) -> next cycle out_valid=1, ALUOP_ARITH, regwrite=1, is_rtype=1, rd=1, rs1=2, rs2=3, illegal=0.
- EN_M=0 vs EN_M=1, push 0x023100B3 (mul) -> illegal_op=1 vs aluop=ALUOP_MUL with illegal_op=0.
- DEPTH=4, out_ready=0, push 5 words -> in_ready falls after the 4th accept. Pop one -> in_ready=1 the next cycle. Entries emerge in order with PC values intact across pointer wrap.
- SERIALIZE=1, push 0x0000100F (fence.i) then offer add -> in_ready=0 until fence.i is popped. Repeat with 0x00000073: sysop=ECALL and the same stall.
- Fill 3 entries, assert flush with in_valid=1 -> next cycle out_valid=0, count=0, in_ready=1, and the flushed-cycle input is absent.
- Push 0xFFFFFFFF and 0x34011073 -> first entry illegal_op=1. Second entry has RESULT_CSR, IMM_Z, regwrite=1.
